// File: rtl/regfile.sv
// regfile: architectural register file with a pending-write scoreboard.
//   x1..x31 hold state; x0 always reads zero and is never written or tracked.
//   Two combinational read ports forward a same-cycle writeback. A per-register
//   counter tracks issued-but-not-written-back destinations so decode can see
//   RAW hazards and is stalled when a counter would overflow.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   wb2rf_bus[37:0]      {we, waddr[4:0], wdata[31:0]} from writeback
//   raddr1/2, rdata1/2   read ports (combinational, write-through forwarding)
//   issue_valid/we/rd    destination reservation from decode
//   issue_ready          reservation can be accepted this cycle
//   hazard1/2            read operand still has an unsatisfied pending write
//   flush                clear all pending-write tracking
//   sb_err               sticky: writeback arrived for an untracked register
module regfile #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [37:0]              wb2rf_bus,
   input  logic [$clog2(NREG)-1:0]  raddr1,
   input  logic [$clog2(NREG)-1:0]  raddr2,
   output logic [31:0]              rdata1,
   output logic [31:0]              rdata2,
   input  logic                     issue_valid,
   input  logic                     issue_we,
   input  logic [$clog2(NREG)-1:0]  issue_rd,
   output logic                     issue_ready,
   output logic                     hazard1,
   output logic                     hazard2,
   input  logic                     flush,
   output logic                     sb_err
);

   localparam int AW = $clog2(NREG);

   logic [31:0]      r_regs [1:NREG-1];
   logic [CNT_W-1:0] r_cnt  [1:NREG-1];
   logic             r_sb_err;

   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [31:0]      w_wdata;
   logic [CNT_W-1:0] w_cnt  [0:NREG-1];
   logic [NREG-1:0]  w_inc;
   logic [NREG-1:0]  w_dec;
   logic             w_err_set;

   assign w_we    = wb2rf_bus[37];
   assign w_waddr = wb2rf_bus[36:32];
   assign w_wdata = wb2rf_bus[31:0];

   // Zero-extended view of the counters so x0 can be indexed uniformly (always 0).
   always_comb begin
      w_cnt[0] = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         w_cnt[r] = r_cnt[r];
      end
   end

   always_comb begin
      w_dec = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         w_dec[r] = w_we && (w_waddr == AW'(r)) && (r_cnt[r] != '0);
      end
   end

   // A saturated counter can still accept a new reservation when it is being
   // retired in the same cycle, since the net count stays the same.
   assign issue_ready = !(issue_we && (issue_rd != '0) &&
                          (w_cnt[issue_rd] == '1) && !w_dec[issue_rd]);

   always_comb begin
      w_inc = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         w_inc[r] = issue_valid && issue_we && issue_ready && (issue_rd == AW'(r));
      end
   end

   assign w_err_set = w_we && (w_waddr != '0) && (w_cnt[w_waddr] == '0);

   // Forwarding only satisfies the reader when the arriving write is the last
   // outstanding one; with more pending the forwarded value is stale.
   always_comb begin
      hazard1 = (raddr1 != '0) && (w_cnt[raddr1] != '0) &&
                !((w_cnt[raddr1] == CNT_W'(1)) && w_dec[raddr1]);
      hazard2 = (raddr2 != '0) && (w_cnt[raddr2] != '0) &&
                !((w_cnt[raddr2] == CNT_W'(1)) && w_dec[raddr2]);
   end

   always_comb begin
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (w_we && (w_waddr == raddr1)) begin
         rdata1 = w_wdata;
      end else begin
         rdata1 = r_regs[raddr1];
      end
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (w_we && (w_waddr == raddr2)) begin
         rdata2 = w_wdata;
      end else begin
         rdata2 = r_regs[raddr2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 1; r < NREG; r++) begin
            r_regs[r] <= '0;
            r_cnt[r]  <= '0;
         end
         r_sb_err <= 1'b0;
      end else begin
         if (w_we && (w_waddr != '0)) begin
            r_regs[w_waddr] <= w_wdata;
         end
         if (w_err_set) begin
            r_sb_err <= 1'b1;
         end
         for (int unsigned r = 1; r < NREG; r++) begin
            if (flush) begin
               r_cnt[r] <= '0;
            end else if (w_inc[r] && !w_dec[r]) begin
               r_cnt[r] <= r_cnt[r] + CNT_W'(1);
            end else if (w_dec[r] && !w_inc[r]) begin
               r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end
         end
      end
   end

   assign sb_err = r_sb_err;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [37:0] wb2rf_bus;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        issue_valid, issue_we;
   logic [4:0]  issue_rd;
   logic        issue_ready, hazard1, hazard2;
   logic        flush;
   logic        sb_err;

   always #5 clk = ~clk;

   regfile #(.NREG(32), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .wb2rf_bus(wb2rf_bus),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .hazard1(hazard1), .hazard2(hazard2),
      .flush(flush), .sb_err(sb_err)
   );

   typedef enum int {S_RD1, S_RD2, S_HZ1, S_HZ2, S_RDY, S_ERR} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Monitor: every expectation queued for the current cycle is compared
   // against the DUT outputs on the falling edge.
   exp_t        e;
   logic [31:0] act;
   always @(negedge clk) begin
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         case (e.sig)
            S_RD1:   act = rdata1;
            S_RD2:   act = rdata2;
            S_HZ1:   act = {31'b0, hazard1};
            S_HZ2:   act = {31'b0, hazard2};
            S_RDY:   act = {31'b0, issue_ready};
            default: act = {31'b0, sb_err};
         endcase
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_v(input string name, input sig_e sig, input logic [31:0] v);
      exp_t x;
      x.name = name; x.sig = sig; x.exp = v;
      sb_q.push_back(x);
   endtask

   task automatic idle();
      rst = 1'b0; wb2rf_bus = '0; raddr1 = '0; raddr2 = '0;
      issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb2rf_bus = {1'b1, a, d};
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();

      // Reset state: every register reads zero, no hazards, ready, no error
      for (int a = 0; a < 32; a++) begin
         idle();
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         expect_v("rst_rd1", S_RD1, 32'h0);
         expect_v("rst_rd2", S_RD2, 32'h0);
         expect_v("rst_hz1", S_HZ1, 0);
         expect_v("rst_hz2", S_HZ2, 0);
         if (a == 0) begin
            expect_v("rst_rdy", S_RDY, 1);
            expect_v("rst_err", S_ERR, 0);
         end
         step();
      end

      // x0 write ignored by storage and scoreboard
      idle(); wb(5'd0, 32'hDEADBEEF);
      expect_v("x0_fwd", S_RD1, 32'h0);
      step();
      idle();
      expect_v("x0_rd", S_RD1, 32'h0);
      expect_v("x0_err", S_ERR, 0);
      step();

      // Single pending write to x5
      idle(); issue(5'd5);
      expect_v("x5_issue_rdy", S_RDY, 1);
      step();
      idle(); raddr1 = 5'd5;
      expect_v("x5_hz_pending", S_HZ1, 1);
      step();
      idle(); raddr1 = 5'd5; wb(5'd5, 32'h1234);
      expect_v("x5_hz_wb", S_HZ1, 0);
      expect_v("x5_fwd", S_RD1, 32'h1234);
      step();
      idle(); raddr1 = 5'd5;
      expect_v("x5_store", S_RD1, 32'h1234);
      expect_v("x5_hz_after", S_HZ1, 0);
      expect_v("x5_err", S_ERR, 0);
      step();

      // Counter saturation on x7
      for (int i = 0; i < 3; i++) begin
         idle(); issue(5'd7);
         expect_v("x7_fill_rdy", S_RDY, 1);
         step();
      end
      idle(); issue(5'd7); raddr2 = 5'd7;
      expect_v("x7_full_rdy", S_RDY, 0);
      expect_v("x7_full_hz", S_HZ2, 1);
      step();
      idle(); issue(5'd7); raddr2 = 5'd7; wb(5'd7, 32'h77);
      expect_v("x7_full_wb_rdy", S_RDY, 1);
      expect_v("x7_full_wb_hz", S_HZ2, 1);
      expect_v("x7_full_wb_fwd", S_RD2, 32'h77);
      step();
      idle(); issue(5'd7);
      expect_v("x7_still_full", S_RDY, 0);
      step();
      idle(); raddr2 = 5'd7; wb(5'd7, 32'h71);
      expect_v("x7_drain3_hz", S_HZ2, 1);
      step();
      idle(); raddr2 = 5'd7; wb(5'd7, 32'h72);
      expect_v("x7_drain2_hz", S_HZ2, 1);
      step();
      idle(); raddr2 = 5'd7; wb(5'd7, 32'h73);
      expect_v("x7_drain1_hz", S_HZ2, 0);
      expect_v("x7_drain1_fwd", S_RD2, 32'h73);
      step();
      idle(); raddr2 = 5'd7;
      expect_v("x7_empty_hz", S_HZ2, 0);
      expect_v("x7_store", S_RD2, 32'h73);
      expect_v("x7_err", S_ERR, 0);
      step();

      // Two pending writes to x9
      idle(); issue(5'd9); step();
      idle(); issue(5'd9); step();
      idle(); raddr1 = 5'd9; wb(5'd9, 32'h11);
      expect_v("x9_first_hz", S_HZ1, 1);
      step();
      idle(); raddr1 = 5'd9; wb(5'd9, 32'h22);
      expect_v("x9_second_hz", S_HZ1, 0);
      expect_v("x9_second_fwd", S_RD1, 32'h22);
      step();
      idle(); raddr1 = 5'd9;
      expect_v("x9_store", S_RD1, 32'h22);
      expect_v("x9_hz_after", S_HZ1, 0);
      step();

      // Flush clears tracking, wins over a same-cycle issue
      idle(); issue(5'd3); step();
      idle(); issue(5'd4); step();
      idle(); raddr1 = 5'd3; raddr2 = 5'd4; flush = 1'b1; issue(5'd10);
      expect_v("fl_pre_hz1", S_HZ1, 1);
      expect_v("fl_pre_hz2", S_HZ2, 1);
      step();
      idle(); raddr1 = 5'd3; raddr2 = 5'd4;
      expect_v("fl_post_hz1", S_HZ1, 0);
      expect_v("fl_post_hz2", S_HZ2, 0);
      step();
      idle(); raddr1 = 5'd10;
      expect_v("fl_issue_dropped", S_HZ1, 0);
      step();
      idle(); raddr1 = 5'd3; wb(5'd3, 32'h3333);
      expect_v("fl_wb_err_now", S_ERR, 0);
      expect_v("fl_wb_fwd", S_RD1, 32'h3333);
      step();
      idle(); raddr1 = 5'd3;
      expect_v("fl_wb_err", S_ERR, 1);
      expect_v("fl_wb_store", S_RD1, 32'h3333);
      step();

      // Reset mid-stream
      idle(); wb(5'd6, 32'h55); step();
      idle(); issue(5'd6); step();
      idle(); issue(5'd6); step();
      idle(); raddr1 = 5'd6;
      expect_v("x6_pre_rd", S_RD1, 32'h55);
      expect_v("x6_pre_hz", S_HZ1, 1);
      step();
      idle(); rst = 1'b1; issue(5'd6); wb(5'd6, 32'h99); flush = 1'b1;
      step();
      idle(); raddr1 = 5'd6; issue_we = 1'b1; issue_rd = 5'd6;
      expect_v("x6_rst_rd", S_RD1, 32'h0);
      expect_v("x6_rst_hz", S_HZ1, 0);
      expect_v("x6_rst_err", S_ERR, 0);
      expect_v("x6_rst_rdy", S_RDY, 1);
      step();
      idle(); wb(5'd6, 32'h66); step();
      idle();
      expect_v("x6_rst_cnt_zero", S_ERR, 1);
      step();

      step();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
